// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS clock.
// Digits are frozen once per frame so a frame never mixes old and new time values.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [2:0] M_out1,
  input  logic [3:0] M_out0,
  input  logic [2:0] S_out1,
  input  logic [3:0] S_out0,
  input  logic       Alarm,
  input  logic       disp_en,
  input  logic       lz_blank,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned IDX_W   = 3;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(5);
  localparam logic [5:0]         AN_OFF     = 6'b111111;
  localparam logic [6:0]         SEG_OFF    = 7'h7F;
  localparam logic [6:0]         SEG_DASH   = 7'b0111111;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               blink_q, blink_d;

  logic [1:0] snap_h1_q, snap_h1_d;
  logic [3:0] snap_h0_q, snap_h0_d;
  logic [2:0] snap_m1_q, snap_m1_d;
  logic [3:0] snap_m0_q, snap_m0_d;
  logic [2:0] snap_s1_q, snap_s1_d;
  logic [3:0] snap_s0_q, snap_s0_d;
  logic       snap_alarm_q, snap_alarm_d;

  logic [5:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic       tick_c, wrap_c, upd_c;
  logic [3:0] digit_c;
  logic [5:0] slot_an_c;

  // Active-low {g,f,e,d,c,b,a}; non-decimal values show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_DASH;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      blink_q      <= 1'b1;
      snap_h1_q    <= '0;
      snap_h0_q    <= '0;
      snap_m1_q    <= '0;
      snap_m0_q    <= '0;
      snap_s1_q    <= '0;
      snap_s0_q    <= '0;
      snap_alarm_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      blink_q      <= blink_d;
      snap_h1_q    <= snap_h1_d;
      snap_h0_q    <= snap_h0_d;
      snap_m1_q    <= snap_m1_d;
      snap_m0_q    <= snap_m0_d;
      snap_s1_q    <= snap_s1_d;
      snap_s0_q    <= snap_s0_d;
      snap_alarm_q <= snap_alarm_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  // Scan timing, frame snapshot and blink phase
  always_comb begin
    tick_c       = (presc_q == PRESC_LAST);
    wrap_c       = tick_c && (idx_q == IDX_LAST);
    presc_d      = tick_c ? '0 : presc_q + PRESC_W'(1);
    idx_d        = idx_q;
    frame_d      = frame_q;
    blink_d      = blink_q;
    snap_h1_d    = snap_h1_q;
    snap_h0_d    = snap_h0_q;
    snap_m1_d    = snap_m1_q;
    snap_m0_d    = snap_m0_q;
    snap_s1_d    = snap_s1_q;
    snap_s0_d    = snap_s0_q;
    snap_alarm_d = snap_alarm_q;

    if (tick_c) begin
      idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
    end

    if (wrap_c) begin
      snap_h1_d    = H_out1;
      snap_h0_d    = H_out0;
      snap_m1_d    = M_out1;
      snap_m0_d    = M_out0;
      snap_s1_d    = S_out1;
      snap_s0_d    = S_out0;
      snap_alarm_d = Alarm;
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  // Output update: one cycle after the index moves; disable darkens immediately
  always_comb begin
    an_d      = an_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    upd_c     = (presc_q == PRESC_W'(0));
    slot_an_c = ~(6'(1) << idx_q);

    case (idx_q)
      IDX_W'(0): digit_c = snap_s0_q;
      IDX_W'(1): digit_c = {1'b0, snap_s1_q};
      IDX_W'(2): digit_c = snap_m0_q;
      IDX_W'(3): digit_c = {1'b0, snap_m1_q};
      IDX_W'(4): digit_c = snap_h0_q;
      default:   digit_c = {2'b00, snap_h1_q};
    endcase

    if (!disp_en) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else if (upd_c) begin
      an_d  = slot_an_c;
      seg_d = seg_decode(digit_c);
      dp_d  = ~(((idx_q == IDX_W'(2)) || (idx_q == IDX_W'(4))) && snap_s0_q[0]);
      if ((idx_q == IDX_LAST) && lz_blank && (snap_h1_q == 2'd0)) begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end
      if (snap_alarm_q && !blink_q) begin
        an_d = AN_OFF;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: per-slot expectations queued and compared mid-slot.
module tb_clock_display_scan;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned BLINK_FRAMES = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [2:0] M_out1;
  logic [3:0] M_out0;
  logic [2:0] S_out1;
  logic [3:0] S_out0;
  logic       Alarm;
  logic       disp_en;
  logic       lz_blank;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  clock_display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .reset(reset),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0), .Alarm(Alarm),
    .disp_en(disp_en), .lz_blank(lz_blank),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  int   snap[6];
  logic snap_alarm = 1'b0;
  logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  task automatic set_time(input int hh, input int mm, input int ss);
    H_out1 = 2'(hh / 10);
    H_out0 = 4'(hh % 10);
    M_out1 = 3'(mm / 10);
    M_out0 = 4'(mm % 10);
    S_out1 = 3'(ss / 10);
    S_out0 = 4'(ss % 10);
  endtask

  task automatic capture_model();
    snap[0]    = int'(S_out0);
    snap[1]    = int'(S_out1);
    snap[2]    = int'(M_out0);
    snap[3]    = int'(M_out1);
    snap[4]    = int'(H_out0);
    snap[5]    = int'(H_out1);
    snap_alarm = Alarm;
  endtask

  // Advance from one mid-slot sample point to the next; the frame snapshot lands on the wrap.
  task automatic step_slot();
    if (k % 6 == 5) capture_model();
    repeat (4) @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  // Expected display for global slot kk, counted from reset release.
  function automatic exp_t model_slot(input int kk);
    exp_t e;
    int   p;
    int   f;
    logic blink;
    p     = kk % 6;
    f     = kk / 6;
    blink = ((f / 2) % 2) == 0;
    e.an    = 6'b111111;
    e.an[p] = 1'b0;
    e.seg   = seg_tbl[snap[p]];
    e.dp    = ((p == 2 || p == 4) && (snap[0] % 2 == 1)) ? 1'b0 : 1'b1;
    if (p == 5 && lz_blank && snap[5] == 0) begin
      e.an  = 6'b111111;
      e.seg = 7'h7F;
    end
    if (snap_alarm && !blink) e.an = 6'b111111;
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) snap[i] = 0;
    snap_alarm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({an, seg, dp} !== {6'b111111, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold: got an=%b seg=%b dp=%b, expected an=111111 seg=1111111 dp=1", an, seg, dp);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    k = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    set_time(12, 34, 56);
    Alarm = 1'b0; disp_en = 1'b1; lz_blank = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) sb.push_back(model_slot(k + i));
    for (int i = 0; i < 6; i++) begin
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL reset_frame k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
      end
      step_slot();
    end
  endtask

  task automatic test_basic();
    exp_t e;
    checks++;
    if ({an, seg} !== {6'b111110, 7'b0000010}) begin
      errors++;
      $display("FAIL basic_slot0: got an=%b seg=%b, expected an=111110 seg=0000010", an, seg);
    end
    for (int i = 0; i < 6; i++) sb.push_back(model_slot(k + i));
    for (int i = 0; i < 6; i++) begin
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL basic k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (i == 5) begin
        checks++;
        if ({an, seg} !== {6'b011111, 7'b1111001}) begin
          errors++;
          $display("FAIL basic_slot5: got an=%b seg=%b, expected an=011111 seg=1111001", an, seg);
        end
      end
      step_slot();
    end
  endtask

  task automatic test_dash_dp();
    exp_t e;
    M_out0 = 4'hB;
    S_out0 = 4'd7;
    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < 6; i++) sb.push_back(model_slot(k + i));
      for (int i = 0; i < 6; i++) begin
        e = sb.pop_front();
        checks++;
        if ({an, seg, dp} !== e) begin
          errors++;
          $display("FAIL dash_dp k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
        if (fr == 1 && i == 2) begin
          checks++;
          if ({seg, dp} !== {7'b0111111, 1'b0}) begin
            errors++;
            $display("FAIL dash_slot2: got seg=%b dp=%b, expected seg=0111111 dp=0", seg, dp);
          end
        end
        step_slot();
      end
    end
  endtask

  task automatic test_lz();
    exp_t e;
    H_out1 = 2'd0;
    H_out0 = 4'd9;
    lz_blank = 1'b1;
    for (int fr = 0; fr < 3; fr++) begin
      if (fr == 2) lz_blank = 1'b0;
      for (int i = 0; i < 6; i++) sb.push_back(model_slot(k + i));
      for (int i = 0; i < 6; i++) begin
        e = sb.pop_front();
        checks++;
        if ({an, seg, dp} !== e) begin
          errors++;
          $display("FAIL lz k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
        step_slot();
      end
    end
  endtask

  task automatic test_mid_frame();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) set_time(23, 59, 48);
      sb.push_back(model_slot(k));
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL mid_frame k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
      end
      step_slot();
    end
  endtask

  task automatic test_capture_edge();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model_slot(k));
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL cap_edge_pre k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (i < 5) step_slot();
    end
    // New values appear only in the half cycle before the wrap edge.
    @(posedge clk);
    @(negedge clk);
    set_time(10, 27, 31);
    capture_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    k++;
    for (int i = 0; i < 6; i++) sb.push_back(model_slot(k + i));
    for (int i = 0; i < 6; i++) begin
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL cap_edge k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
      end
      step_slot();
    end
  endtask

  task automatic test_alarm();
    exp_t e;
    Alarm = 1'b1;
    for (int fr = 0; fr < 9; fr++) begin
      if (fr == 7) Alarm = 1'b0;
      for (int i = 0; i < 6; i++) sb.push_back(model_slot(k + i));
      for (int i = 0; i < 6; i++) begin
        e = sb.pop_front();
        checks++;
        if ({an, seg, dp} !== e) begin
          errors++;
          $display("FAIL alarm k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
        step_slot();
      end
    end
  endtask

  task automatic test_disp_en();
    exp_t e;
    sb.push_back(model_slot(k));
    e = sb.pop_front();
    checks++;
    if ({an, seg, dp} !== e) begin
      errors++;
      $display("FAIL disp_lit k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
    end
    disp_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({an, seg, dp} !== {6'b111111, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL disp_off_1cyc: got an=%b seg=%b dp=%b, expected an=111111 seg=1111111 dp=1", an, seg, dp);
    end
    @(negedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    k++;
    for (int i = 0; i < 3; i++) begin
      sb.push_back({6'b111111, 7'h7F, 1'b1});
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL disp_dark k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (i == 2) disp_en = 1'b1;
      step_slot();
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model_slot(k));
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL disp_reenable k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
      end
      step_slot();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model_slot(k));
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL pre_reset k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
      end
      step_slot();
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {6'b111111, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_async: got an=%b seg=%b dp=%b, expected an=111111 seg=1111111 dp=1", an, seg, dp);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model_slot(k));
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL post_reset k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, e.an, e.seg, e.dp);
      end
      step_slot();
    end
  endtask

  initial begin
    set_time(0, 0, 0);
    Alarm = 1'b0; disp_en = 1'b1; lz_blank = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_dash_dp();
    test_lz();
    test_mid_frame();
    test_capture_edge();
    test_alarm();
    test_disp_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot (minimum 2).
REQ-002 Parameter BLINK_FRAMES, default 64, full scan frames per alarm-blink half-period (minimum 1).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 H_out1 input 2, H_out0 input 4, M_out1 input 3, M_out0 input 4, S_out1 input 3, S_out0 input 4  BCD time digits from the clock stage.
REQ-006 Alarm  input  1  alarm-active flag from the clock stage.
REQ-007 disp_en  input  1  1 = display lit, 0 = all digits dark.
REQ-008 lz_blank  input  1  1 = blank hour-tens digit when it is 0.
REQ-009 an  output  6  digit enables, active-low; an[0] = S_out0 position ... an[5] = H_out1 position.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1 and wraps; a tick is the cycle in which it equals SCAN_DIV-1.
REQ-013 Digit index (0..5) SHALL advance by 1 on each tick and wrap 5->0; a frame is one pass over indices 0..5.
REQ-014 On the tick that wraps the index 5->0, all six digit inputs and Alarm SHALL be captured into snapshot registers; display uses only snapshots (no intra-frame tearing).
REQ-015 an, seg, dp SHALL be registered and update in the cycle after a tick (1-cycle latency from index change).
REQ-016 Exactly one an bit low when lit: an[idx] = 0, others 1.
REQ-017 Decode values 0-9 to standard patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, 9 = 7'b0010000); values 10-15 SHALL display dash (7'b0111111).
REQ-018 Snapshot H_out1/M_out1/S_out1 SHALL be zero-extended to 4 bits before decoding.
REQ-019 If lz_blank = 1 and snapshot H_out1 = 0, slot 5 SHALL drive an[5] = 1 and seg = 7'h7F.
REQ-020 dp SHALL be 0 on slots 2 and 4 when snapshot S_out0[0] = 1, else 1 (blinking separators).
REQ-021 Frame counter counts 0..BLINK_FRAMES-1 on each frame wrap; on its terminal wrap blink_phase toggles.
REQ-022 While snapshot Alarm = 1 and blink_phase = 0, an SHALL be 6'b111111 (whole display flashes); with Alarm = 0, blink_phase ignored.
REQ-023 disp_en = 0 forces an = 6'b111111, seg = 7'h7F, dp = 1 at the next output update or within 1 cycle, whichever is first; prescaler, index, frame counter keep running.
REQ-024 Input changes in the same cycle as the capture tick SHALL be captured (inputs sampled on that edge).
REQ-025 Snapshot Alarm falling mid-blink SHALL restore lighting at the next output update; blink_phase not reset.

Reset
REQ-026 reset = 0 asynchronously sets: prescaler 0, index 0, frame counter 0, blink_phase 1, snapshots 0, an = 6'b111111, seg = 7'h7F, dp = 1.
REQ-027 After reset release, first capture occurs at the first 5->0 wrap; until then, displayed digits are snapshot zeros.
REQ-028 Reset asserted mid-frame SHALL take effect immediately without waiting for clk.

Verification (SCAN_DIV = 4, BLINK_FRAMES = 2)
REQ-029 Inputs 12:34:56, disp_en = 1, lz_blank = 0 -> after first capture, an cycles 111110 to 011111 every 4 clk; seg for slot 0 = 6 (7'b0000010), slot 5 = 1 (7'b1111001).
REQ-030 H_out1 = 0, lz_blank = 1 -> slot 5 an = 111111, seg = 7'h7F; lz_blank = 0 -> shows 7'b1000000.
REQ-031 Alarm = 1 held -> an all ones for 2 frames (48 clk), lit for 2 frames, repeating; Alarm = 0 -> lit every frame.
REQ-032 M_out0 = 4'hB -> slot 2 seg = 7'b0111111; S_out0 odd -> dp = 0 on slots 2 and 4 only.
REQ-033 Change inputs mid-frame -> display unchanged until next 5->0 wrap, then new values.
REQ-034 reset low at mid-slot -> outputs at reset values in same cycle; disp_en = 0 -> an = 111111 while index keeps advancing (checked on re-enable slot).
